// File: rtl/fp_mul_operand_stage.sv
// ---------------------------------------------------------------------------
// fp_mul_operand_stage
//
// Registered operand-issue stage in front of the approximate binary32
// multiplier. Each accepted operand pair is split into sign/exponent/mantissa
// fields. Special operands (zero, denormal, inf, NaN) are resolved into a
// ready-made bypass word. The payload is presented from a 2-entry skid buffer:
// a main output register plus one skid register. in_ready is a pure register
// output, so there is no combinational path from out_ready.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready = ~skid_valid)
//   op_a, op_b               packed binary32 operands
//   out_valid / out_ready    output handshake towards the multiplier
//   sign_x/y, exp_x/y,       operand fields; exponent and mantissa are
//   mantissa_x/y             forced to 0 when special=1
//   special, special_word    bypass result (special_word=0 when special=0)
//   special_cnt, ftz_cnt     saturating event counters, updated on accept
// ---------------------------------------------------------------------------
module fp_mul_operand_stage #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   op_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   op_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           sign_x,
    output logic                           sign_y,
    output logic [EXP_WIDTH-1:0]           exp_x,
    output logic [EXP_WIDTH-1:0]           exp_y,
    output logic [MAN_WIDTH-1:0]           mantissa_x,
    output logic [MAN_WIDTH-1:0]           mantissa_y,
    output logic                           special,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   special_word,
    output logic [15:0]                    special_cnt,
    output logic [15:0]                    ftz_cnt
);

    localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

    // Canonical quiet NaN: sign 0, exponent all ones, MSB of fraction set.
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                 sign_x;
        logic                 sign_y;
        logic [EXP_WIDTH-1:0] exp_x;
        logic [EXP_WIDTH-1:0] exp_y;
        logic [MAN_WIDTH-1:0] man_x;
        logic [MAN_WIDTH-1:0] man_y;
        logic                 special;
        logic [W-1:0]         special_word;
    } payload_t;

    // ---------------------------------------------------------------- classify
    logic [EXP_WIDTH-1:0] exp_a, exp_b;
    logic [MAN_WIDTH-1:0] man_a, man_b;
    logic                 a_zero, b_zero, a_den, b_den, a_inf, b_inf, a_nan, b_nan;
    logic                 res_sign;
    payload_t             new_pl;

    assign exp_a  = op_a[W-2:MAN_WIDTH];
    assign exp_b  = op_b[W-2:MAN_WIDTH];
    assign man_a  = op_a[MAN_WIDTH-1:0];
    assign man_b  = op_b[MAN_WIDTH-1:0];

    // Denormals are flushed, so "zero" covers every exp==0 encoding.
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_den  = a_zero && (man_a != '0);
    assign b_den  = b_zero && (man_b != '0);
    assign a_inf  = (exp_a == '1) && (man_a == '0);
    assign b_inf  = (exp_b == '1) && (man_b == '0);
    assign a_nan  = (exp_a == '1) && (man_a != '0);
    assign b_nan  = (exp_b == '1) && (man_b != '0);

    assign res_sign = op_a[W-1] ^ op_b[W-1];

    always_comb begin
        new_pl        = '0;
        new_pl.sign_x = op_a[W-1];
        new_pl.sign_y = op_b[W-1];
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            new_pl.special      = 1'b1;
            new_pl.special_word = QNAN;
        end else if (a_inf || b_inf) begin
            new_pl.special      = 1'b1;
            new_pl.special_word = {res_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
        end else if (a_zero || b_zero) begin
            new_pl.special      = 1'b1;
            new_pl.special_word = {res_sign, {(W-1){1'b0}}};
        end else begin
            new_pl.exp_x = exp_a;
            new_pl.exp_y = exp_b;
            new_pl.man_x = man_a;
            new_pl.man_y = man_b;
        end
    end

    // ---------------------------------------------------------------- counters
    logic [1:0]  ftz_inc;
    logic [16:0] ftz_sum;
    logic [15:0] ftz_nxt;
    logic [15:0] spc_nxt;

    assign ftz_inc = {1'b0, a_den} + {1'b0, b_den};
    assign ftz_sum = {1'b0, ftz_cnt} + 17'(ftz_inc);
    // Carry out of the 17-bit sum means we crossed FFFF: clamp.
    assign ftz_nxt = ftz_sum[16] ? 16'hFFFF : ftz_sum[15:0];
    assign spc_nxt = (new_pl.special && (special_cnt != 16'hFFFF)) ? special_cnt + 16'd1
                                                                   : special_cnt;

    // ------------------------------------------------------------ skid buffer
    payload_t main_q, skid_q;
    logic     skid_valid;
    logic     accept, drain;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            special_cnt <= '0;
            ftz_cnt     <= '0;
        end else begin
            if (accept) begin
                special_cnt <= spc_nxt;
                ftz_cnt     <= ftz_nxt;
            end
            if (drain) begin
                // skid_valid implies in_ready=0, so no accept can collide here.
                if (skid_valid) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= new_pl;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (!out_valid) begin
                if (accept) begin
                    main_q    <= new_pl;
                    out_valid <= 1'b1;
                end
            end else if (accept) begin
                // Stalled: main holds still, park the new pair in skid.
                skid_q     <= new_pl;
                skid_valid <= 1'b1;
            end
        end
    end

    assign sign_x       = main_q.sign_x;
    assign sign_y       = main_q.sign_y;
    assign exp_x        = main_q.exp_x;
    assign exp_y        = main_q.exp_y;
    assign mantissa_x   = main_q.man_x;
    assign mantissa_y   = main_q.man_y;
    assign special      = main_q.special;
    assign special_word = main_q.special_word;

endmodule
